// File: rtl/polyram_reader.sv
// polyram_reader: burst reader for a synchronous RAM with two-edge read latency.
// A start request latches a base address and a word count, then the block issues
// one read per cycle through a registered address (ra), tracks each read through
// a three-stage valid pipeline and lands the returned word in a 4-entry FIFO that
// drives a valid/ready output. Issue is throttled so that reads in flight plus
// buffered words never exceed the FIFO depth, so the FIFO can never overflow.
//
// Ports:
//   clk   - single clock, also clocks the RAM read port
//   rst   - asynchronous active-low reset
//   start - one-cycle burst request; base/len sampled with it (ignored while busy)
//   base  - first RAM address of the burst
//   len   - number of words (0 .. 1<<AWID)
//   busy  - burst in progress
//   done  - one-cycle pulse when the burst has completed
//   ra    - registered RAM read address
//   rdo   - RAM read data, valid two edges after ra is presented
//   odat  - output word (oldest FIFO entry)
//   ovld  - odat valid
//   ordy  - downstream ready; transfer on an edge with ovld && ordy
module polyram_reader #(
  parameter int unsigned WID  = 256,
  parameter int unsigned AWID = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AWID-1:0] base,
  input  logic [AWID:0]   len,
  output logic            busy,
  output logic            done,
  output logic [AWID-1:0] ra,
  input  logic [WID-1:0]  rdo,
  output logic [WID-1:0]  odat,
  output logic            ovld,
  input  logic            ordy
);

  localparam logic [AWID-1:0] RaOne  = 1;
  localparam logic [AWID:0]   CntOne = 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [AWID-1:0] ra_q, ra_d;
  logic [AWID:0]   rd_left_q, rd_left_d;  // reads still to issue
  logic [AWID:0]   xf_left_q, xf_left_d;  // words still to hand downstream
  // [0]: address on ra, [1]: address inside RAM, [2]: data on rdo this cycle
  logic [2:0]      vld_q, vld_d;
  logic            done_q, done_d;

  logic [WID-1:0]  buf_q [4];
  logic [1:0]      wr_ptr_q, wr_ptr_d;
  logic [1:0]      rd_ptr_q, rd_ptr_d;
  logic [2:0]      cnt_q, cnt_d;

  logic            issue;
  logic            xfer;
  logic            capture;
  logic [3:0]      occ;

  assign xfer    = (cnt_q != 3'd0) && ordy;
  assign capture = vld_q[2];
  // Occupancy after this edge, not counting a new issue: a word leaving this
  // edge frees a slot, which is what lets the reader sustain one word per cycle.
  assign occ = 4'(vld_q[0]) + 4'(vld_q[1]) + 4'(vld_q[2]) + 4'(cnt_q) - 4'(xfer);

  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    rd_left_d = rd_left_q;
    xf_left_d = xf_left_q;
    done_d    = 1'b0;
    issue     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            // The start edge itself issues the first read at base.
            issue     = 1'b1;
            ra_d      = base;
            rd_left_d = len - CntOne;
            xf_left_d = len;
            state_d   = StRun;
          end
        end
      end
      StRun: begin
        if (rd_left_q == '0) begin
          state_d = StDrain;
        end else if (occ < 4'd4) begin
          issue     = 1'b1;
          ra_d      = ra_q + RaOne;
          rd_left_d = rd_left_q - CntOne;
          if (rd_left_q == CntOne) state_d = StDrain;
        end
      end
      StDrain: begin
      end
      default: state_d = StIdle;
    endcase

    if (xfer) begin
      xf_left_d = xf_left_q - CntOne;
      if (xf_left_q == CntOne) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end
  end

  always_comb begin
    vld_d    = {vld_q[1:0], issue};
    wr_ptr_d = capture ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = xfer ? rd_ptr_q + 2'd1 : rd_ptr_q;
    cnt_d    = cnt_q + 3'(capture) - 3'(xfer);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      ra_q      <= '0;
      rd_left_q <= '0;
      xf_left_q <= '0;
      vld_q     <= '0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_d;
      rd_left_q <= rd_left_d;
      xf_left_q <= xf_left_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      if (capture) buf_q[wr_ptr_q] <= rdo;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign ra   = ra_q;
  assign odat = buf_q[rd_ptr_q];
  assign ovld = (cnt_q != 3'd0);

endmodule

// File: doc/polyram_reader.md
POLYRAM_READER -- requirements
Module: polyram_reader

Interface
REQ-001 SHALL provide parameter WID, default 256, RAM word width in bits.
REQ-002 SHALL provide parameter AWID, default 5, RAM address width; RAM depth 1<<AWID.
REQ-003 SHALL provide port clk  input  1  single clock for all logic; the RAM read port runs on this clock.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port start  input  1  one-cycle request to begin a burst.
REQ-006 SHALL provide port base  input  AWID  first RAM address of the burst, sampled with start.
REQ-007 SHALL provide port len  input  AWID+1  number of words in the burst (0..1<<AWID), sampled with start.
REQ-008 SHALL provide port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL provide port done  output  1  one-cycle pulse at burst completion.
REQ-010 SHALL provide port ra  output  AWID  registered RAM read address.
REQ-011 SHALL provide port rdo  input  WID  RAM read data, valid two clk edges after ra is presented.
REQ-012 SHALL provide port odat  output  WID  output word.
REQ-013 SHALL provide port ovld  output  1  odat valid.
REQ-014 SHALL provide port ordy  input  1  downstream ready; a word transfers on a clk edge with ovld and ordy both high.

Function
REQ-015 SHALL implement FSM IDLE, RUN, DRAIN: IDLE->RUN on start with len>0; RUN->DRAIN on the edge issuing the final read; DRAIN->IDLE on the edge transferring the final word.
REQ-016 SHALL, on start with len=0 in IDLE, issue no reads, keep busy low, and pulse done on the following cycle.
REQ-017 SHALL ignore start while busy; base and len are not resampled.
REQ-018 SHALL issue one read per cycle in RUN when in-flight reads plus buffered words is less than 4; issue = ra loaded with next address on that edge.
REQ-019 SHALL present ra=base on the cycle after start, then increment ra by 1 modulo 1<<AWID per issued read (base=31 -> 31,0,1,...).
REQ-020 SHALL track each issued read through a 3-stage valid pipeline (ra edge, RAM address edge, RAM data edge) and capture rdo into the output buffer on the edge after the data edge.
REQ-021 SHALL hold an output buffer of 4 WID-bit entries, FIFO order; odat = oldest entry; ovld = buffer non-empty.
REQ-022 SHALL never overflow the buffer: in-flight plus buffered never exceeds 4, including simultaneous capture and transfer.
REQ-023 SHALL hold odat and ovld stable while ovld=1 and ordy=0.
REQ-024 SHALL sustain one word per cycle with ordy held high; first ovld on the 4th cycle after the start edge.
REQ-025 SHALL deliver exactly len words in address order, with no duplicates or drops under any ordy pattern.
REQ-026 SHALL assert done for one cycle, on the cycle after the final word transfers, and drop busy in that same cycle.
REQ-027 SHALL accept a new start in the cycle done is high (FSM is IDLE).
REQ-028 SHALL retain ra at its last value when not issuing.

Reset
REQ-029 SHALL, on rst low, immediately force FSM=IDLE, busy=0, done=0, ovld=0, ra=0, odat=0, in-flight pipeline cleared, buffer empty.
REQ-030 SHALL, after rst deasserts mid-burst, discard that burst entirely; RAM data returning after reset is not captured.

Verification
REQ-031 SHALL pass: RAM preloaded mem[i]=i, start base=0 len=32, ordy=1 -> ovld first high 4 cycles after start, odat 0..31 on 32 consecutive cycles, done one cycle later.
REQ-032 SHALL pass: base=30 len=4, ordy=1 -> ra sequence 30,31,0,1; odat 30,31,0,1.
REQ-033 SHALL pass: len=8, ordy low for 10 cycles after start -> ovld high with odat=word0 held, exactly 4 reads issued, then release ordy -> 8 words in order, no loss.
REQ-034 SHALL pass: len=16, ordy random 50% -> 16 words in order, buffered+in-flight never exceeds 4.
REQ-035 SHALL pass: start len=0 -> no ra change, busy stays 0, done pulses next cycle; start during busy -> ignored, original burst unchanged.
REQ-036 SHALL pass: rst asserted at word 5 of a 32-word burst -> all outputs at reset values immediately; new burst afterwards returns correct data starting at its base.
